// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the rx FIFO and the CSR block.
// UART_RX_FIFO_FERR_EN adds a per-byte frame-error bit alongside the data.
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_finish;
    logic        i_pop;
    logic [7:0]  o_data;
    logic        o_empty;
    logic        o_full;
    logic [AW:0] o_level;
    logic        o_overrun;
    logic        i_overrun_clr;
    logic        o_irq;
`ifdef UART_RX_FIFO_FERR_EN
    logic        i_frame_err;
    logic        o_frame_err;
`endif

    modport slave (
`ifdef UART_RX_FIFO_FERR_EN
        input  i_frame_err,
        output o_frame_err,
`endif
        input  i_rx_data, i_rx_valid, i_pop, i_overrun_clr,
        output o_rx_finish, o_data, o_empty, o_full, o_level, o_overrun, o_irq
    );

    modport master (
`ifdef UART_RX_FIFO_FERR_EN
        output i_frame_err,
        input  o_frame_err,
`endif
        output i_rx_data, i_rx_valid, i_pop, i_overrun_clr,
        input  o_rx_finish, o_data, o_empty, o_full, o_level, o_overrun, o_irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO (first-word-fall-through) with occupancy, overrun and interrupt status.
// Optional UART_RX_FIFO_FERR_EN stores a frame-error bit with each byte and raises o_irq on it.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int THRESH = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    uart_rx_fifo_if.slave    bus
);

`ifdef UART_RX_FIFO_FERR_EN
    localparam int W = 9;
`else
    localparam int W = 8;
`endif

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  wdata;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          busy_q, busy_d;
    logic          finish_q, finish_d;
    logic          overrun_q, overrun_d;
    logic          irq_q, irq_d;
    logic          head_ferr_d;

    logic          capture, push_en, pop_en, drop;

`ifdef UART_RX_FIFO_FERR_EN
    assign wdata = {bus.i_frame_err, bus.i_rx_data};
`else
    assign wdata = bus.i_rx_data;
`endif

    // A held i_rx_valid is captured once; busy re-arms only after the strobe drops.
    always_comb begin
        capture     = bus.i_rx_valid && !busy_q && !finish_q;
        pop_en      = bus.i_pop && !empty_q;
        push_en     = capture && (!full_q || pop_en);
        drop        = capture && full_q && !bus.i_pop;

        wr_ptr_d    = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_en  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d     = level_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        empty_d     = (level_d == '0);
        full_d      = (level_d == (AW+1)'(DEPTH));
        busy_d      = capture ? 1'b1 : (bus.i_rx_valid ? busy_q : 1'b0);
        finish_d    = capture;
        overrun_d   = drop ? 1'b1 : (bus.i_overrun_clr ? 1'b0 : overrun_q);

        head_ferr_d = 1'b0;
`ifdef UART_RX_FIFO_FERR_EN
        // The next head may be the entry being written this very cycle.
        if (!empty_d) begin
            if (push_en && (rd_ptr_d == wr_ptr_q))
                head_ferr_d = bus.i_frame_err;
            else
                head_ferr_d = mem[rd_ptr_d][8];
        end
`endif
        irq_d = (level_d >= (AW+1)'(THRESH)) || overrun_d || head_ferr_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && push_en)
            mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.o_data      = mem[rd_ptr_q][7:0];
    assign bus.o_empty     = empty_q;
    assign bus.o_full      = full_q;
    assign bus.o_level     = level_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_irq       = irq_q;
    assign bus.o_rx_finish = finish_q;
`ifdef UART_RX_FIFO_FERR_EN
    assign bus.o_frame_err = mem[rd_ptr_q][8];
`endif

endmodule
